// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of an asynchronous PWM input in clk
// cycles and derives a 16-bit duty fraction with a restoring serial divider.
module pwm_capture #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [15:0]      duty,
    output logic             meas_valid,
    output logic             overrun,
    output logic             signal_lost
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic {
        ST_ARM  = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [15:0] duty_sat(input logic sat, input logic [15:0] q);
        return sat ? 16'hFFFF : q;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_p0;
    logic                   pwm_p1;
    logic                   rise;
    logic                   fall;
    logic                   timeout;
    logic [CNT_W-1:0]       cnt;
    state_t                 state_q;
    state_t                 state_d;
    logic                   latch_hi;
    logic                   start_div;
    logic                   drop_meas;
    logic [CNT_W-1:0]       hi_lat;
    logic                   div_busy;
    logic [4:0]             div_step;
    logic                   div_done;
    logic [CNT_W-1:0]       div_per;
    logic [CNT_W-1:0]       div_hi;
    logic [CNT_W:0]         div_rem;
    logic                   div_sat;
    logic [14:0]            div_q;
    logic [CNT_W:0]         rem_sh;
    logic [CNT_W:0]         rem_nxt;
    logic                   q_bit;

    // Stage p0: synchronized level; stage p1: one-cycle delay for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            pwm_p1 <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            pwm_p1 <= pwm_p0;
        end
    end

    assign pwm_p0  = sync_q[SYNC_STAGES-1];
    assign rise    = pwm_p0 & ~pwm_p1;
    assign fall    = ~pwm_p0 & pwm_p1;
    assign timeout = (cnt == TIMEOUT_CNT) && !rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (timeout) begin
            cnt <= '0;
        end else begin
            cnt <= sat_inc(cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_ARM;
        end else if ((state_q == ST_ARM) && rise) begin
            state_d = ST_MEAS;
        end
    end

    always_comb begin
        latch_hi  = 1'b0;
        start_div = 1'b0;
        drop_meas = 1'b0;
        if (state_q == ST_MEAS) begin
            latch_hi  = fall;
            start_div = rise & ~div_busy;
            drop_meas = rise & div_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_hi) begin
            hi_lat <= cnt;
        end
    end

    // Divider control: 16 iteration cycles, then one settle cycle before accepting a new load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_busy <= 1'b0;
            div_step <= '0;
        end else if (timeout) begin
            div_busy <= 1'b0;
        end else if (start_div) begin
            div_busy <= 1'b1;
            div_step <= '0;
        end else if (div_busy) begin
            if (div_step == 5'd16) begin
                div_busy <= 1'b0;
            end
            div_step <= div_step + 5'd1;
        end
    end

    assign div_done = div_busy && (div_step == 5'd15) && !timeout;
    assign rem_sh   = div_rem << 1;
    assign q_bit    = rem_sh >= {1'b0, div_per};
    assign rem_nxt  = q_bit ? (rem_sh - {1'b0, div_per}) : rem_sh;

    always_ff @(posedge clk) begin
        if (start_div) begin
            div_per <= cnt;
            div_hi  <= hi_lat;
            div_rem <= {1'b0, hi_lat};
            div_sat <= hi_lat >= cnt;
            div_q   <= '0;
        end else if (div_busy && !div_step[4]) begin
            div_rem <= rem_nxt;
            div_q   <= {div_q[13:0], q_bit};
        end
    end

    // Output stage: final quotient bit folds straight into duty on the last iteration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period      <= '0;
            high_time   <= '0;
            duty        <= '0;
            meas_valid  <= 1'b0;
            overrun     <= 1'b0;
            signal_lost <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            overrun    <= drop_meas;
            if (timeout) begin
                signal_lost <= 1'b1;
                period      <= '0;
                high_time   <= '0;
                duty        <= pwm_p0 ? 16'hFFFF : 16'h0000;
            end else if (div_done) begin
                period      <= div_per;
                high_time   <= div_hi;
                duty        <= duty_sat(div_sat, {div_q, q_bit});
                meas_valid  <= 1'b1;
                signal_lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM patterns one tick per clock and
// checks measured period/high_time/duty, pulses and timeout behaviour.
module tb_pwm_capture;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [15:0]      duty;
    logic             meas_valid;
    logic             overrun;
    logic             signal_lost;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  mv_cnt = 0;
    int  ovr_cnt = 0;
    int  mv_tick = 0;
    int  mv_gap = 0;
    int  rise_tick = 0;
    int  lost_tick = 0;
    int  saved = 0;
    bit  lost_seen = 1'b0;

    always #5 clk = ~clk;

    pwm_capture #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (1000),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .duty       (duty),
        .meas_valid (meas_valid),
        .overrun    (overrun),
        .signal_lost(signal_lost)
    );

    // One clock: sample outputs on the falling edge, then drive the next input level
    task automatic tick(input logic lvl);
        @(negedge clk);
        cyc++;
        if (meas_valid) begin
            mv_cnt++;
            mv_gap  = cyc - mv_tick;
            mv_tick = cyc;
        end
        if (overrun) ovr_cnt++;
        if (signal_lost && !lost_seen) begin
            lost_seen = 1'b1;
            lost_tick = cyc;
        end
        if (lvl && !pwm_in) rise_tick = cyc;
        pwm_in = lvl;
    endtask

    task automatic run_pwm(input int per, input int hi, input int first, input int n);
        for (int i = first; i < first + n; i++) tick((i % per) < hi);
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) tick(lvl);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        hold(1'b0, 3);
        reset = 1'b0;
        tick(1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hold(1'b0, 4);
        n_vec++; if (period !== 32'd0) begin n_err++; $display("FAIL reset_period: got %0d want 0", period); end
        n_vec++; if (high_time !== 32'd0) begin n_err++; $display("FAIL reset_high: got %0d want 0", high_time); end
        n_vec++; if (duty !== 16'd0) begin n_err++; $display("FAIL reset_duty: got %0d want 0", duty); end
        n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_mv: got %b want 0", meas_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        n_vec++; if (signal_lost !== 1'b0) begin n_err++; $display("FAIL reset_lost: got %b want 0", signal_lost); end
        reset = 1'b0;
        tick(1'b0);
    endtask

    task automatic test_basic();
        mv_cnt = 0; ovr_cnt = 0;
        run_pwm(100, 25, 0, 600);
        hold(1'b0, 50);
        n_vec++; if (mv_cnt !== 5) begin n_err++; $display("FAIL basic_mv_count: got %0d want 5", mv_cnt); end
        n_vec++; if (mv_gap !== 100) begin n_err++; $display("FAIL basic_mv_gap: got %0d want 100", mv_gap); end
        n_vec++; if (ovr_cnt !== 0) begin n_err++; $display("FAIL basic_overrun: got %0d want 0", ovr_cnt); end
        n_vec++; if (period !== 32'd100) begin n_err++; $display("FAIL basic_period: got %0d want 100", period); end
        n_vec++; if (high_time !== 32'd25) begin n_err++; $display("FAIL basic_high: got %0d want 25", high_time); end
        n_vec++; if (duty !== 16'd16384) begin n_err++; $display("FAIL basic_duty: got %0d want 16384", duty); end
        n_vec++; if (signal_lost !== 1'b0) begin n_err++; $display("FAIL basic_lost: got %b want 0", signal_lost); end
    endtask

    task automatic test_extreme_duty();
        run_pwm(1000, 1, 0, 3000);
        n_vec++; if (period !== 32'd1000) begin n_err++; $display("FAIL low_duty_period: got %0d want 1000", period); end
        n_vec++; if (high_time !== 32'd1) begin n_err++; $display("FAIL low_duty_high: got %0d want 1", high_time); end
        n_vec++; if (duty !== 16'd65) begin n_err++; $display("FAIL low_duty_duty: got %0d want 65", duty); end
        n_vec++; if (signal_lost !== 1'b0) begin n_err++; $display("FAIL low_duty_lost: got %b want 0", signal_lost); end
        run_pwm(1000, 999, 0, 3000);
        n_vec++; if (period !== 32'd1000) begin n_err++; $display("FAIL high_duty_period: got %0d want 1000", period); end
        n_vec++; if (high_time !== 32'd999) begin n_err++; $display("FAIL high_duty_high: got %0d want 999", high_time); end
        n_vec++; if (duty !== 16'd65470) begin n_err++; $display("FAIL high_duty_duty: got %0d want 65470", duty); end
        n_vec++; if (signal_lost !== 1'b0) begin n_err++; $display("FAIL high_duty_lost: got %b want 0", signal_lost); end
    endtask

    task automatic test_timeout();
        run_pwm(100, 25, 0, 300);
        lost_seen = 1'b0;
        hold(1'b1, 30);
        saved = mv_cnt;
        hold(1'b1, 980);
        n_vec++; if (signal_lost !== 1'b1) begin n_err++; $display("FAIL to_high_lost: got %b want 1", signal_lost); end
        n_vec++; if (lost_tick - rise_tick !== 1003) begin n_err++; $display("FAIL to_high_latency: got %0d want 1003", lost_tick - rise_tick); end
        n_vec++; if (duty !== 16'hFFFF) begin n_err++; $display("FAIL to_high_duty: got %0d want 65535", duty); end
        n_vec++; if (period !== 32'd0) begin n_err++; $display("FAIL to_high_period: got %0d want 0", period); end
        n_vec++; if (high_time !== 32'd0) begin n_err++; $display("FAIL to_high_high: got %0d want 0", high_time); end
        n_vec++; if (mv_cnt !== saved) begin n_err++; $display("FAIL to_no_mv: got %0d want %0d", mv_cnt, saved); end
        hold(1'b0, 1100);
        n_vec++; if (duty !== 16'd0) begin n_err++; $display("FAIL to_low_duty: got %0d want 0", duty); end
        n_vec++; if (signal_lost !== 1'b1) begin n_err++; $display("FAIL to_low_lost: got %b want 1", signal_lost); end
        run_pwm(100, 25, 0, 50);
        n_vec++; if (signal_lost !== 1'b1) begin n_err++; $display("FAIL to_restart_held: got %b want 1", signal_lost); end
        run_pwm(100, 25, 50, 250);
        n_vec++; if (signal_lost !== 1'b0) begin n_err++; $display("FAIL to_restart_clear: got %b want 0", signal_lost); end
        n_vec++; if (period !== 32'd100) begin n_err++; $display("FAIL to_restart_period: got %0d want 100", period); end
        n_vec++; if (duty !== 16'd16384) begin n_err++; $display("FAIL to_restart_duty: got %0d want 16384", duty); end
    endtask

    task automatic test_overrun();
        apply_reset();
        mv_cnt = 0; ovr_cnt = 0;
        run_pwm(4, 2, 0, 80);
        hold(1'b0, 30);
        n_vec++; if (mv_cnt !== 4) begin n_err++; $display("FAIL ovr_mv_count: got %0d want 4", mv_cnt); end
        n_vec++; if (ovr_cnt !== 15) begin n_err++; $display("FAIL ovr_count: got %0d want 15", ovr_cnt); end
        n_vec++; if (period !== 32'd4) begin n_err++; $display("FAIL ovr_period: got %0d want 4", period); end
        n_vec++; if (high_time !== 32'd2) begin n_err++; $display("FAIL ovr_high: got %0d want 2", high_time); end
        n_vec++; if (duty !== 16'd32768) begin n_err++; $display("FAIL ovr_duty: got %0d want 32768", duty); end
    endtask

    task automatic test_reset_mid_divide();
        run_pwm(100, 5, 0, 101);
        mv_cnt = 0;
        run_pwm(100, 5, 101, 9);
        reset = 1'b1;
        hold(1'b0, 2);
        n_vec++; if (period !== 32'd0) begin n_err++; $display("FAIL rst_div_period: got %0d want 0", period); end
        n_vec++; if (high_time !== 32'd0) begin n_err++; $display("FAIL rst_div_high: got %0d want 0", high_time); end
        n_vec++; if (duty !== 16'd0) begin n_err++; $display("FAIL rst_div_duty: got %0d want 0", duty); end
        reset = 1'b0;
        run_pwm(100, 5, 112, 250);
        n_vec++; if (mv_cnt !== 1) begin n_err++; $display("FAIL rst_div_mv_count: got %0d want 1", mv_cnt); end
        n_vec++; if (mv_tick - rise_tick !== 19) begin n_err++; $display("FAIL rst_div_latency: got %0d want 19", mv_tick - rise_tick); end
        n_vec++; if (period !== 32'd100) begin n_err++; $display("FAIL rst_div_period2: got %0d want 100", period); end
        n_vec++; if (high_time !== 32'd5) begin n_err++; $display("FAIL rst_div_high2: got %0d want 5", high_time); end
        n_vec++; if (duty !== 16'd3276) begin n_err++; $display("FAIL rst_div_duty2: got %0d want 3276", duty); end
    endtask

    task automatic test_back_to_back();
        run_pwm(100, 50, 0, 300);
        run_pwm(200, 150, 0, 25);
        n_vec++; if (period !== 32'd100) begin n_err++; $display("FAIL b2b_old_period: got %0d want 100", period); end
        n_vec++; if (duty !== 16'd32768) begin n_err++; $display("FAIL b2b_old_duty: got %0d want 32768", duty); end
        run_pwm(200, 150, 25, 200);
        n_vec++; if (period !== 32'd200) begin n_err++; $display("FAIL b2b_new_period: got %0d want 200", period); end
        n_vec++; if (high_time !== 32'd150) begin n_err++; $display("FAIL b2b_new_high: got %0d want 150", high_time); end
        n_vec++; if (duty !== 16'd49152) begin n_err++; $display("FAIL b2b_new_duty: got %0d want 49152", duty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme_duty();
        test_timeout();
        test_overrun();
        test_reset_mid_divide();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
